// File: rtl/quad_step_decoder_if.sv
// Quadrature decoder signal bundle: raw A/B and error clear in; step pulse, direction, status out.
interface quad_step_decoder_if;
  logic       i_a;
  logic       i_b;
  logic       i_clr_err;
  logic       o_en;
  logic       o_up_down;
  logic       o_err;
  logic [1:0] o_state;

  modport master (output i_a, i_b, i_clr_err, input  o_en, o_up_down, o_err, o_state);
  modport slave  (input  i_a, i_b, i_clr_err, output o_en, o_up_down, o_err, o_state);
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature front-end: per-channel 2-flop sync and glitch filter, then a Gray-step
// decoder producing a count-enable pulse, direction level and sticky illegal-step flag.
module qsd_chan #(
  parameter int FILT_LEN = 3
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic raw,
  input  logic init,
  output logic sync_q,
  output logic stable
);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  logic          sync1;
  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync1  <= 1'b0;
      sync_q <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= raw;
      sync_q <= sync1;
      // Init window: adopt whatever the line idles at, so no step is ever seen.
      if (init) begin
        stable <= sync_q;
        cnt    <= '0;
      end else if (sync_q == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module quad_step_decoder #(
  parameter int FILT_LEN = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  quad_step_decoder_if.slave   bus
);
  localparam int IW = $clog2(FILT_LEN + 3);
  localparam logic [IW-1:0] INIT_LEN = IW'(FILT_LEN + 2);

  logic [IW-1:0] init_cnt;
  logic          init;
  logic [1:0]    raw, sync2, stable, prev, diff;
  logic          en_q, ud_q, err_q;

  assign raw  = {bus.i_a, bus.i_b};
  assign init = (init_cnt != INIT_LEN);
  assign diff = prev ^ stable;

  for (genvar c = 0; c < 2; c++) begin : g_chan
    qsd_chan #(.FILT_LEN(FILT_LEN)) u_chan (
      .gclk   (i_clk),
      .grst_n (i_rst_n),
      .raw    (raw[c]),
      .init   (init),
      .sync_q (sync2[c]),
      .stable (stable[c])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_cnt <= '0;
      prev     <= 2'b00;
      en_q     <= 1'b0;
      ud_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (init) begin
      // prev follows what stable is loading this edge, so both leave init equal.
      init_cnt <= init_cnt + 1'b1;
      prev     <= sync2;
      en_q     <= 1'b0;
      err_q    <= err_q & ~bus.i_clr_err;
    end else begin
      prev  <= stable;
      en_q  <= ^diff;
      // Up order 00->10->11->01->00 reduces to prev.b ^ new.a for single-bit steps.
      if (^diff) ud_q <= prev[0] ^ stable[1];
      err_q <= (err_q & ~bus.i_clr_err) | (&diff);
    end
  end

  assign bus.o_en      = en_q;
  assign bus.o_up_down = ud_q;
  assign bus.o_err     = err_q;
  assign bus.o_state   = stable;
endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: FILT_LEN=3 and FILT_LEN=1 instances.
module tb_quad_step_decoder;
  localparam int F_EN = 0, F_UD = 1, F_ERR = 2, F_ST = 3;

  typedef struct { int cyc; logic ud; logic [1:0] st; } pulse_t;
  typedef struct { int cyc; int dut; int fld; logic [1:0] exp; string name; } probe_t;

  logic clk = 1'b0;
  logic rst3_n, rst1_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  pulse_t q3[$];
  pulse_t q1[$];
  probe_t pq[$];
  logic [1:0] cur3;

  quad_step_decoder_if b3();
  quad_step_decoder_if b1();

  quad_step_decoder #(.FILT_LEN(3)) u_dut3 (.i_clk(clk), .i_rst_n(rst3_n), .bus(b3.slave));
  quad_step_decoder #(.FILT_LEN(1)) u_dut1 (.i_clk(clk), .i_rst_n(rst1_n), .bus(b1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0][1:0] obs3, obs1;
  assign obs3 = {b3.o_state, {1'b0, b3.o_err}, {1'b0, b3.o_up_down}, {1'b0, b3.o_en}};
  assign obs1 = {b1.o_state, {1'b0, b1.o_err}, {1'b0, b1.o_up_down}, {1'b0, b1.o_en}};

  task automatic chk_pulse(input int dut, input logic en, input logic ud, input logic [1:0] st);
    pulse_t e;
    int     n;
    n = (dut == 3) ? q3.size() : q1.size();
    if (n > 0) e = (dut == 3) ? q3[0] : q1[0];
    if (en) begin
      tests++;
      if (n == 0 || e.cyc != cyc) begin
        fails++;
        $display("FAIL unexpected_en dut%0d cyc=%0d got en=1 required next pulse at cyc=%0d",
                 dut, cyc, (n == 0) ? -1 : e.cyc);
      end else begin
        if (dut == 3) void'(q3.pop_front()); else void'(q1.pop_front());
        n--;
        if (ud !== e.ud || st !== e.st) begin
          fails++;
          $display("FAIL pulse dut%0d cyc=%0d got ud=%b st=%b required ud=%b st=%b",
                   dut, cyc, ud, st, e.ud, e.st);
        end
        if (n > 0) e = (dut == 3) ? q3[0] : q1[0];
      end
    end
    if (n > 0 && e.cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_en dut%0d cyc=%0d got en=0 required en=1 at cyc=%0d", dut, cyc, e.cyc);
      if (dut == 3) void'(q3.pop_front()); else void'(q1.pop_front());
    end
  endtask

  // Monitor: pulses and scheduled probes are compared here only.
  always @(negedge clk) begin
    chk_pulse(3, b3.o_en, b3.o_up_down, b3.o_state);
    chk_pulse(1, b1.o_en, b1.o_up_down, b1.o_state);
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].cyc <= cyc) begin
        logic [1:0] a;
        a = (pq[i].dut == 3) ? obs3[pq[i].fld] : obs1[pq[i].fld];
        tests++;
        if (a !== pq[i].exp) begin
          fails++;
          $display("FAIL %s dut%0d cyc=%0d got=%b required=%b", pq[i].name, pq[i].dut, cyc, a, pq[i].exp);
        end
        pq.delete(i);
      end
    end
  end

  task automatic probe(input int c, input int dut, input int fld, input logic [1:0] exp, input string name);
    probe_t p;
    p.cyc = c; p.dut = dut; p.fld = fld; p.exp = exp; p.name = name;
    pq.push_back(p);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // FILT_LEN=3: change captured at k, stable at k+4, o_en seen at k+5.
  task automatic step3(input logic a, input logic b, input logic ud);
    int k;
    k = cyc + 1;
    b3.i_a = a; b3.i_b = b;
    probe(k + 3, 3, F_ST, cur3, "state_before");
    cur3 = {a, b};
    q3.push_back('{k + 5, ud, cur3});
    probe(k + 4, 3, F_ST, cur3, "state_after");
    ticks(10);
  endtask

  initial begin
    int k, m, p, r;
    rst3_n = 1'b0; rst1_n = 1'b0;
    b3.i_a = 0; b3.i_b = 0; b3.i_clr_err = 0;
    b1.i_a = 0; b1.i_b = 0; b1.i_clr_err = 0;
    cur3 = 2'b00;
    ticks(2);
    probe(cyc + 1, 3, F_ST, 2'b00, "rst_state");
    probe(cyc + 1, 3, F_UD, 2'b00, "rst_ud");
    probe(cyc + 1, 3, F_ERR, 2'b00, "rst_err");
    probe(cyc + 1, 1, F_EN, 2'b00, "rst_en");
    ticks(2);
    rst3_n = 1'b1; rst1_n = 1'b1;
    ticks(10);

    // up then down sweep
    step3(1, 0, 1); step3(1, 1, 1); step3(0, 1, 1); step3(0, 0, 1);
    step3(0, 1, 0); step3(1, 1, 0); step3(1, 0, 0); step3(0, 0, 0);

    // 2-sample glitch is dropped
    k = cyc + 1;
    b3.i_a = 1; ticks(2); b3.i_a = 0;
    probe(k + 5, 3, F_ST, 2'b00, "glitch_state");
    probe(k + 8, 3, F_ST, 2'b00, "glitch_state_late");
    ticks(10);

    // 3-sample pulse passes, and its fall is a down step
    k = cyc + 1;
    b3.i_a = 1;
    q3.push_back('{k + 5, 1'b1, 2'b10});
    probe(k + 4, 3, F_ST, 2'b10, "pulse3_rise");
    ticks(3);
    b3.i_a = 0;
    k = cyc + 1;
    q3.push_back('{k + 5, 1'b0, 2'b00});
    probe(k + 4, 3, F_ST, 2'b00, "pulse3_fall");
    ticks(12);
    cur3 = 2'b00;
    step3(1, 0, 1);

    // async reset mid-filter with a pending step
    b3.i_a = 0;
    ticks(2);
    @(posedge clk); #2;
    rst3_n = 1'b0;
    probe(cyc, 3, F_ST, 2'b00, "async_rst_state");
    probe(cyc, 3, F_UD, 2'b00, "async_rst_ud");
    probe(cyc, 3, F_EN, 2'b00, "async_rst_en");
    probe(cyc, 3, F_ERR, 2'b00, "async_rst_err");
    @(negedge clk);
    b3.i_a = 1; b3.i_b = 1;
    ticks(3);

    // release with inputs idling at 11
    r = cyc;
    rst3_n = 1'b1;
    cur3 = 2'b11;
    probe(r + 4, 3, F_EN, 2'b00, "idle_en");
    probe(r + 5, 3, F_ST, 2'b11, "idle_state");
    probe(r + 6, 3, F_ERR, 2'b00, "idle_err");
    probe(r + 15, 3, F_ST, 2'b11, "idle_state_late");
    probe(r + 15, 3, F_ERR, 2'b00, "idle_err_late");
    ticks(20);

    // FILT_LEN=1: up step, then illegal 10->01
    k = cyc + 1;
    b1.i_a = 1;
    q1.push_back('{k + 3, 1'b1, 2'b10});
    probe(k + 2, 1, F_ST, 2'b10, "f1_state");
    ticks(8);
    k = cyc + 1;
    b1.i_a = 0; b1.i_b = 1;
    probe(k + 2, 1, F_ERR, 2'b00, "err_before");
    probe(k + 3, 1, F_ERR, 2'b01, "err_set");
    probe(k + 4, 1, F_UD, 2'b01, "err_ud_held");
    probe(k + 4, 1, F_ST, 2'b01, "err_state");
    ticks(8);

    // clear
    m = cyc;
    b1.i_clr_err = 1; ticks(1); b1.i_clr_err = 0;
    probe(m + 1, 1, F_ERR, 2'b00, "clr");
    probe(m + 3, 1, F_ERR, 2'b00, "clr_hold");
    ticks(5);

    // clear coincident with a new error
    p = cyc;
    b1.i_a = 1; b1.i_b = 0;
    probe(p + 3, 1, F_ERR, 2'b00, "coinc_before");
    ticks(3);
    b1.i_clr_err = 1; ticks(1); b1.i_clr_err = 0;
    probe(p + 4, 1, F_ERR, 2'b01, "coinc_err_wins");
    probe(p + 6, 1, F_ERR, 2'b01, "coinc_sticky");
    probe(p + 6, 1, F_UD, 2'b01, "coinc_ud_held");
    ticks(6);

    // async reset clears the sticky flag
    @(posedge clk); #2;
    rst1_n = 1'b0;
    probe(cyc, 1, F_ERR, 2'b00, "f1_rst_err");
    probe(cyc, 1, F_UD, 2'b00, "f1_rst_ud");
    probe(cyc, 1, F_ST, 2'b00, "f1_rst_state");
    @(negedge clk);
    b1.i_a = 0;
    rst1_n = 1'b1;
    ticks(15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
